alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-client arbiter and protocol controller for the serial ALU. Accepts parallel operation requests (A, B, opcode) from two requesters and grants the ALU round-robin. It serializes the granted request into the ALU input frame stream (8 DATA frames plus 1 CTL frame with CRC4) on `sin`, then deserializes the response from `sout` (CTL result or ERR frame). The decoded result is returned to the requester that owns the transaction. It sits between the system-side masters and the ALU core; only one transaction is in flight at a time.

## Interface
- `TIMEOUT`, default 255: cycles allowed with `sout` idle while awaiting a response start bit before the arbiter aborts.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: client request pending.
- `req0_ready` / `req1_ready` out 1: high in the cycle the request is accepted (grant); reset 0.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in 32: operands.
- `req0_op` / `req1_op` in 3: opcode: and 000, or 001, add 100, sub 101. Any other value is forwarded unchanged.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle response pulse to the owning client; reset 0.
- `rsp_c` out 32: result, shared by both clients; reset 0.
- `rsp_flags` out 4: {carry, overflow, zero, negative}; reset 0.
- `rsp_err` out 3: {err_data, err_crc, err_op} from an ERR frame; reset 0.
- `rsp_timeout` out 1: response aborted by timeout; reset 0.
- `sin` out 1: serial stream to ALU; idle and reset value 1.
- `sout` in 1: serial stream from ALU; idle 1.

## Operation
- Frame format, both directions: 11 bits, one bit per clk: start 0, type bit (0 DATA, 1 CTL/ERR), 8 payload bits MSB first, stop 1.
- States: IDLE → SEND → WAIT → RECV → DONE → IDLE.
- **IDLE:** if any `reqN_valid`, grant one client. Round-robin: the client not granted last wins a tie. After reset, client 0 wins the first tie. Pulse `reqN_ready`, latch A, B, op and owner.
- **SEND:** emit B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] … A[7:0] as DATA frames. Then emit the CTL frame with payload {0, op[2:0], crc4[3:0]}.
  - crc4 is the CRC over the 68-bit stream {B, A, 1'b1, op}, MSB first, polynomial x^4+x+1, init 0.
  - Frames are back-to-back with no idle gap: 99 bits total.
- **WAIT:** `sin` = 1. Count cycles from the end of the last stop bit. The first 0 on `sout` moves to RECV and clears the counter. If the counter reaches TIMEOUT, go to DONE with `rsp_timeout` = 1.
- **RECV:** shift frames.
  - DATA frames fill C MSB byte first.
  - First non-DATA frame: payload bit7 = 0 means CTL. Capture `rsp_flags` = payload[6:3]; `rsp_err` = 0.
  - Payload bit7 = 1 means ERR. Capture `rsp_err` = payload[6:4]; `rsp_flags` = 0; C = 0. This is valid even if fewer than 4 DATA frames preceded it.
  - A 5th DATA frame (a DATA frame after 4) is a protocol error: set `rsp_err` = 3'b111.
  - Response CRC3 is not checked.
- **DONE:** one cycle. Pulse `rspN_valid` for the owner only, with `rsp_*` stable that cycle. Outputs hold until the next DONE.
- Requests arriving during SEND/WAIT/RECV wait; `ready` stays low.
- Async reset at any point: return to IDLE, `sin` = 1, all outputs to reset values, round-robin pointer to client 0, in-flight transaction dropped with no response.

## Timing
- Grant in cycle T (`ready` = 1); first start bit on `sin` at T+1; CTL stop bit at T+99.
- WAIT begins at T+100.
- `rspN_valid` asserts the cycle after the stop bit of the final response frame is sampled.
- The earliest next grant is the cycle after DONE.
- `sout` is sampled on rising edges with no synchronizer; the ALU shares `clk`.
- Timeout: `rsp_timeout` pulses with `rspN_valid` exactly TIMEOUT+1 cycles after WAIT entry.

## Test plan
- **AND, client 0:** A=0xFFFF0000, B=0x0F0F0F0F, op=000. Expected: `sin` carries 8 DATA frames then CTL with crc4 matching the model. ALU reply yields `rsp0_valid`, `rsp_c` = 0x0F0F0000, `rsp_err` = 0.
- **Simultaneous requests:** `req0`/`req1` asserted together and held. Expected grants 0, 1, 0, 1. Each `rspN_valid` goes only to its owner; `req1_ready` never overlaps an active transaction.
- **ERR reply:** stub ALU returns a single ERR frame with payload 0xA5. Expected `rsp_err` = 3'b010, `rsp_c` = 0, `rsp_flags` = 0.
- **Timeout:** `sout` held at 1 with TIMEOUT=16. Expected `rsp_timeout` = 1 and `rsp1_valid` 17 cycles after WAIT entry; next request accepted normally.
- **Reset mid-SEND:** `rst_n` low during the 4th frame. Expected `sin` = 1 immediately, no `rsp*_valid`, and the next tie grants client 0.
- **Add with carry:** A=0xFFFFFFFF, B=1, op=100 on the real ALU. Expected `rsp_c` = 0, `rsp_flags` with carry = 1 and zero = 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-client round-robin front end for the serial ALU: serializes a granted
// request onto sin and decodes the DATA/CTL/ERR response frames from sout.
module alu_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic [2:0]  rsp_err,
  output logic        rsp_timeout,
  output logic        sin,
  input  logic        sout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (TW > 7) ? TW : 7;
  localparam logic [CW-1:0] TO_CNT    = CW'(TIMEOUT);
  localparam logic [CW-1:0] SEND_LAST = CW'(99);
  localparam logic [CW-1:0] STOP_POS  = CW'(9);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  function automatic logic [3:0] crc4(input logic [67:0] bits);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ bits[67 - i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Whole request stream (8 DATA + 1 CTL frame) built at grant time, MSB sent first.
  function automatic logic [98:0] build_frames(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] op);
    logic [63:0] d;
    logic [98:0] f;
    d = {b, a};
    f = '1;
    for (int unsigned i = 0; i < 8; i++)
      f[98 - 11*i -: 11] = {2'b00, d[63 - 8*i -: 8], 1'b1};
    f[10:0] = {2'b01, 1'b0, op, crc4({b, a, 1'b1, op}), 1'b1};
    return f;
  endfunction

  state_t        state_q;
  logic          ptr_q, owner_q;
  logic          rdy0_q, rdy1_q, rspv0_q, rspv1_q;
  logic [31:0]   rsp_c_q, acc_q;
  logic [3:0]    rsp_flags_q;
  logic [2:0]    rsp_err_q, ndata_q;
  logic          rsp_to_q, sin_q, in_frame_q;
  logic [98:0]   tx_q;
  logic [8:0]    rx_q;
  logic [CW-1:0] cnt_q;

  logic          gnt_any, gnt_sel, is_ctl;
  logic [31:0]   sel_a, sel_b, fin_c;
  logic [2:0]    sel_op, fin_err;
  logic [3:0]    fin_flags;
  logic [98:0]   frames_d;

  always_comb begin
    gnt_any   = req0_valid | req1_valid;
    gnt_sel   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    sel_a     = gnt_sel ? req1_a : req0_a;
    sel_b     = gnt_sel ? req1_b : req0_b;
    sel_op    = gnt_sel ? req1_op : req0_op;
    frames_d  = build_frames(sel_a, sel_b, sel_op);
    // A terminating DATA frame can only be the fifth one: protocol error.
    is_ctl    = rx_q[8] & ~rx_q[7];
    fin_c     = is_ctl ? acc_q : '0;
    fin_flags = is_ctl ? rx_q[6:3] : '0;
    fin_err   = !rx_q[8] ? 3'b111 : (rx_q[7] ? rx_q[6:4] : 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      rdy0_q      <= 1'b0;
      rdy1_q      <= 1'b0;
      rspv0_q     <= 1'b0;
      rspv1_q     <= 1'b0;
      rsp_c_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= '0;
      rsp_to_q    <= 1'b0;
      sin_q       <= 1'b1;
      in_frame_q  <= 1'b0;
      acc_q       <= '0;
      ndata_q     <= '0;
      tx_q        <= '1;
      rx_q        <= '0;
      cnt_q       <= '0;
    end else begin
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      rspv0_q <= 1'b0;
      rspv1_q <= 1'b0;
      case (state_q)
        // DONE arbitrates like IDLE so a waiting client is granted right after it.
        S_IDLE, S_DONE: begin
          sin_q <= 1'b1;
          if (gnt_any) begin
            state_q <= S_SEND;
            owner_q <= gnt_sel;
            ptr_q   <= ~gnt_sel;
            rdy0_q  <= ~gnt_sel;
            rdy1_q  <= gnt_sel;
            tx_q    <= frames_d;
            cnt_q   <= '0;
            acc_q   <= '0;
            ndata_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SEND: begin
          sin_q <= tx_q[98];
          tx_q  <= {tx_q[97:0], 1'b1};
          if (cnt_q == SEND_LAST) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (!sout) begin
            state_q    <= S_RECV;
            cnt_q      <= '0;
            in_frame_q <= 1'b1;
          end else if (cnt_q == TO_CNT) begin
            state_q     <= S_DONE;
            rspv0_q     <= ~owner_q;
            rspv1_q     <= owner_q;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= '0;
            rsp_to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RECV: begin
          if (!in_frame_q) begin
            if (!sout) begin
              in_frame_q <= 1'b1;
              cnt_q      <= '0;
            end
          end else if (cnt_q != STOP_POS) begin
            rx_q  <= {rx_q[7:0], sout};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            in_frame_q <= 1'b0;
            if (!rx_q[8] && ndata_q != 3'd4) begin
              acc_q   <= {acc_q[23:0], rx_q[7:0]};
              ndata_q <= ndata_q + 1'b1;
            end else begin
              state_q     <= S_DONE;
              rspv0_q     <= ~owner_q;
              rspv1_q     <= owner_q;
              rsp_c_q     <= fin_c;
              rsp_flags_q <= fin_flags;
              rsp_err_q   <= fin_err;
              rsp_to_q    <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = rdy0_q;
  assign req1_ready  = rdy1_q;
  assign rsp0_valid  = rspv0_q;
  assign rsp1_valid  = rspv1_q;
  assign rsp_c       = rsp_c_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign sin         = sin_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: checks the sin frame stream against a CRC
// long-division model and plays a stub ALU on sout.
module tb_alu_arbiter;

  localparam int K_OK = 0, K_ERR = 1, K_ERR2 = 2, K_DATA5 = 3, K_TO = 4;

  typedef struct {
    int          cl;
    logic [31:0] a, b;
    logic [2:0]  op;
    int          kind;
    logic [7:0]  pay;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  er;
    logic        to;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid, rsp_timeout, sin;
  logic        sout = 1'b1;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_err;

  int checks = 0, failures = 0;
  int pulses0 = 0, pulses1 = 0, overlap = 0;
  logic busy = 1'b0;

  alu_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .sin(sin), .sout(sout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      if ((req0_ready || req1_ready) && busy) overlap <= overlap + 1;
      if (rsp0_valid) pulses0 <= pulses0 + 1;
      if (rsp1_valid) pulses1 <= pulses1 + 1;
      if (rsp0_valid || rsp1_valid) busy <= 1'b0;
      else if (req0_ready || req1_ready) busy <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Remainder of M(x)*x^4 mod (x^4+x+1).
  function automatic logic [3:0] tb_crc4(input logic [67:0] m);
    logic [71:0] v;
    v = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [10:0] fr(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  function automatic logic [98:0] exp_frames(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    logic [3:0] c;
    c = tb_crc4({b, a, 1'b1, op});
    return {fr(1'b0, b[31:24]), fr(1'b0, b[23:16]), fr(1'b0, b[15:8]), fr(1'b0, b[7:0]),
            fr(1'b0, a[31:24]), fr(1'b0, a[23:16]), fr(1'b0, a[15:8]), fr(1'b0, a[7:0]),
            fr(1'b1, {1'b0, op, c})};
  endfunction

  function automatic vec_t mk(input int cl, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input int kind, input logic [7:0] pay,
                              input logic [31:0] c, input logic [3:0] fl,
                              input logic [2:0] er, input logic to);
    vec_t v;
    v.cl = cl; v.a = a; v.b = b; v.op = op; v.kind = kind; v.pay = pay;
    v.c = c; v.fl = fl; v.er = er; v.to = to;
    return v;
  endfunction

  task automatic send_frame(input logic t, input logic [7:0] p);
    logic [10:0] f;
    f = fr(t, p);
    for (int i = 10; i >= 0; i--) begin
      sout = f[i];
      @(negedge clk);
    end
  endtask

  // Entered in the grant cycle; returns just after the cycle following rspN_valid.
  task automatic serve(input vec_t v);
    logic [98:0] got;
    int p0, p1, quiet;
    p0 = pulses0;
    p1 = pulses1;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      got[98 - i] = sin;
    end
    chk("sin_frames", 128'(got), 128'(exp_frames(v.a, v.b, v.op)));
    if (v.kind == K_TO) begin
      quiet = 0;
      repeat (17) begin
        @(negedge clk);
        if (rsp0_valid || rsp1_valid) quiet++;
      end
      chk("timeout_early_valid", 128'(quiet), 128'(0));
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
      case (v.kind)
        K_OK: begin
          for (int k = 0; k < 4; k++) send_frame(1'b0, v.c[31 - 8*k -: 8]);
          send_frame(1'b1, {1'b0, v.fl, 3'b000});
        end
        K_ERR: send_frame(1'b1, v.pay);
        K_ERR2: begin
          send_frame(1'b0, 8'h11);
          send_frame(1'b0, 8'h22);
          send_frame(1'b1, v.pay);
        end
        default: repeat (5) send_frame(1'b0, 8'h5A);
      endcase
    end
    chk("rsp_valid_owner", 128'({rsp1_valid, rsp0_valid}), 128'(v.cl != 0 ? 2'b10 : 2'b01));
    chk("rsp_c", 128'(rsp_c), 128'(v.c));
    chk("rsp_flags", 128'(rsp_flags), 128'(v.fl));
    chk("rsp_err", 128'(rsp_err), 128'(v.er));
    chk("rsp_timeout", 128'(rsp_timeout), 128'(v.to));
    @(negedge clk);
    #1;
    chk("rsp_valid_one_cycle", 128'({rsp1_valid, rsp0_valid}), 128'(0));
    chk("rsp_c_hold", 128'(rsp_c), 128'(v.c));
    chk("pulses0", 128'(pulses0 - p0), 128'(v.cl == 0 ? 1 : 0));
    chk("pulses1", 128'(pulses1 - p1), 128'(v.cl == 1 ? 1 : 0));
  endtask

  task automatic do_txn(input vec_t v);
    bit ok;
    ok = 1'b0;
    if (v.cl == 0) begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_valid = 1'b1; req1_valid = 1'b0;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_valid = 1'b1; req0_valid = 1'b0;
    end
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      ok = req0_ready | req1_ready;
    end
    chk("grant", 128'({req1_ready, req0_ready}), 128'(v.cl != 0 ? 2'b10 : 2'b01));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    serve(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    vec_t s0, s1;
    bit ok;
    int pr0, pr1, sinbad;

    vt[0] = mk(0, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000, K_OK,    8'h00, 32'h0F0F0000, 4'b0000, 3'b000, 1'b0);
    vt[1] = mk(1, 32'h12340000, 32'h00005678, 3'b001, K_OK,    8'h00, 32'h12345678, 4'b0000, 3'b000, 1'b0);
    vt[2] = mk(0, 32'hFFFFFFFF, 32'h00000001, 3'b100, K_OK,    8'h00, 32'h00000000, 4'b1010, 3'b000, 1'b0);
    vt[3] = mk(1, 32'h00000005, 32'h00000007, 3'b101, K_OK,    8'h00, 32'hFFFFFFFE, 4'b0001, 3'b000, 1'b0);
    vt[4] = mk(0, 32'h0000000A, 32'h0000000B, 3'b111, K_ERR,   8'h91, 32'h0,        4'b0000, 3'b001, 1'b0);
    vt[5] = mk(1, 32'h11111111, 32'h22222222, 3'b000, K_ERR,   8'hA5, 32'h0,        4'b0000, 3'b010, 1'b0);
    vt[6] = mk(0, 32'h01020304, 32'h05060708, 3'b001, K_ERR2,  8'hC0, 32'h0,        4'b0000, 3'b100, 1'b0);
    vt[7] = mk(1, 32'h0BADF00D, 32'h00C0FFEE, 3'b100, K_DATA5, 8'h00, 32'h0,        4'b0000, 3'b111, 1'b0);
    vt[8] = mk(1, 32'h00000001, 32'h00000002, 3'b101, K_TO,    8'h00, 32'h0,        4'b0000, 3'b000, 1'b1);
    vt[9] = mk(1, 32'h7FFFFFFF, 32'h00000001, 3'b100, K_OK,    8'h00, 32'h80000000, 4'b0101, 3'b000, 1'b0);
    s0 = mk(0, 32'h00000003, 32'h00000004, 3'b100, K_OK, 8'h00, 32'h00000007, 4'b0000, 3'b000, 1'b0);
    s1 = mk(1, 32'h00000010, 32'h00000020, 3'b101, K_OK, 8'h00, 32'hFFFFFFF0, 4'b0001, 3'b000, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_sin", 128'(sin), 128'(1));
    chk("reset_ready", 128'({req1_ready, req0_ready}), 128'(0));
    chk("reset_valid", 128'({rsp1_valid, rsp0_valid}), 128'(0));
    chk("reset_rsp", 128'({rsp_c, rsp_flags, rsp_err, rsp_timeout}), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) do_txn(vt[i]);

    // Held simultaneous requests: grants must alternate 0,1,0,1 with no idle gap.
    req0_a = s0.a; req0_b = s0.b; req0_op = s0.op;
    req1_a = s1.a; req1_b = s1.b; req1_op = s1.op;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      ok = req0_ready | req1_ready;
    end
    for (int g = 0; g < 4; g++) begin
      chk("rr_grant", 128'({req1_ready, req0_ready}), 128'(g % 2 == 1 ? 2'b10 : 2'b01));
      serve(g % 2 == 1 ? s1 : s0);
    end
    chk("rr_grant5", 128'({req1_ready, req0_ready}), 128'(2'b01));
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // The fifth grant (client 0) is aborted by reset during its 4th frame.
    repeat (38) @(negedge clk);
    chk("pre_reset_sin", 128'(sin), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("midsend_reset_sin", 128'(sin), 128'(1));
    chk("midsend_reset_out", 128'({req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 128'(0));
    chk("midsend_reset_rsp", 128'({rsp_c, rsp_flags, rsp_err, rsp_timeout}), 128'(0));
    pr0 = pulses0;
    pr1 = pulses1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    sinbad = 0;
    repeat (150) begin
      @(negedge clk);
      if (sin !== 1'b1) sinbad++;
    end
    #1;
    chk("post_reset_sin_idle", 128'(sinbad), 128'(0));
    chk("post_reset_no_rsp", 128'({pulses1 - pr1, pulses0 - pr0}), 128'(0));

    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      ok = req0_ready | req1_ready;
    end
    chk("post_reset_tie", 128'({req1_ready, req0_ready}), 128'(2'b01));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    serve(s0);

    chk("ready_overlap", 128'(overlap), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
